// File: rtl/taglist_pkg.sv
// ---------------------------------------------------------------------------
// taglist_pkg : end codes, FSM encoding and tag-entry field offsets
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package taglist_pkg;

  localparam logic [1:0] LE_CONT = 2'b00;
  localparam logic [1:0] LE_RSVD = 2'b01;
  localparam logic [1:0] LE_SEQ  = 2'b10;
  localparam logic [1:0] LE_ROM  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Entry layout, LSB first: final, last, first, seqNum
  function automatic int last_lsb();
    return 1;
  endfunction

  function automatic int first_lsb(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int seq_lsb(input int addr_w);
    return 2 * addr_w + 1;
  endfunction

  function automatic int entry_bits(input int addr_w, input int seq_w);
    return 2 * addr_w + seq_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/taglist_entry_pack.sv
// ---------------------------------------------------------------------------
// taglist_entry_pack : packs {seqNum, first, last, final} into a zero-filled word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module taglist_entry_pack
  import taglist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SEQ_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic [SEQ_W-1:0]  seq_i,
  input  logic [ADDR_W-1:0] first_i,
  input  logic [ADDR_W-1:0] last_i,
  input  logic              final_i,
  output logic [DATA_W-1:0] entry_o
);

  localparam int LAST_LSB  = last_lsb();
  localparam int FIRST_LSB = first_lsb(ADDR_W);
  localparam int SEQ_LSB   = seq_lsb(ADDR_W);

  always_comb begin
    entry_o                      = '0;
    entry_o[0]                   = final_i;
    entry_o[LAST_LSB  +: ADDR_W] = last_i;
    entry_o[FIRST_LSB +: ADDR_W] = first_i;
    entry_o[SEQ_LSB   +: SEQ_W]  = seq_i;
  end

endmodule

`default_nettype wire

// File: rtl/taglist_gen_param.sv
// ---------------------------------------------------------------------------
// taglist_gen_param : walks the pattern ROM and writes one tag entry per sequence
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module taglist_gen_param
  import taglist_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SEQ_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk_1KHz,
  input  logic              reset,
  input  logic              start,
  input  logic              scan_valid,
  input  logic [1:0]        lastEnd,
  input  logic              ram_ready,
  output logic [DATA_W-1:0] ramData,
  output logic [SEQ_W-1:0]  seqNum,
  output logic              w_e_RAM,
  output logic [ADDR_W-1:0] seqWire,
  output logic              busy,
  output logic              done,
  output logic [SEQ_W:0]    count,
  output logic              overflow,
  output logic              code_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEQ_W:0]    cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ovf_q, ovf_d;
  logic              cerr_q, cerr_d;
  logic              final_q, final_d;

  logic              addr_max;
  logic              seq_max;
  logic              pack_final;
  logic [DATA_W-1:0] packed_entry;

  assign addr_max   = (addr_q == {ADDR_W{1'b1}});
  assign seq_max    = (seq_q == {SEQ_W{1'b1}});
  // End-of-ROM, or a continuation at the last address that cannot advance
  assign pack_final = (lastEnd == LE_ROM) || (!lastEnd[1] && addr_max);

  taglist_entry_pack #(
    .ADDR_W (ADDR_W),
    .SEQ_W  (SEQ_W),
    .DATA_W (DATA_W)
  ) u_pack (
    .seq_i   (seq_q),
    .first_i (first_q),
    .last_i  (addr_q),
    .final_i (pack_final),
    .entry_o (packed_entry)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    first_d = first_q;
    seq_d   = seq_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ovf_d   = ovf_q;
    cerr_d  = cerr_q;
    final_d = final_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SCAN;
          addr_d  = '0;
          first_d = '0;
          seq_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          cerr_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (scan_valid) begin
          case (lastEnd)
            LE_SEQ, LE_ROM: begin
              data_d  = packed_entry;
              we_d    = 1'b1;
              final_d = pack_final;
              state_d = ST_WRITE;
            end
            default: begin
              if (lastEnd == LE_RSVD) cerr_d = 1'b1;
              if (addr_max) begin
                ovf_d   = 1'b1;
                data_d  = packed_entry;
                we_d    = 1'b1;
                final_d = 1'b1;
                state_d = ST_WRITE;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (ram_ready) begin
          we_d  = 1'b0;
          cnt_d = cnt_q + 1'b1;
          if (final_q) begin
            state_d = ST_DONE;
          end else if (seq_max) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            seq_d   = seq_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            first_d = addr_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1KHz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      first_q <= '0;
      seq_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cerr_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      cerr_q  <= cerr_d;
      final_q <= final_d;
    end
  end

  assign ramData  = data_q;
  assign seqNum   = seq_q;
  assign w_e_RAM  = we_q;
  assign seqWire  = addr_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign code_err = cerr_q;
  assign busy     = (state_q == ST_SCAN) || (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_taglist_gen_param.sv
// ---------------------------------------------------------------------------
// tb_taglist_gen_param : randomized directed bench against a sequence-list model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_taglist_gen_param;

  localparam int ADDR_W   = 10;
  localparam int SEQ_W    = 7;
  localparam int DATA_W   = 32;
  localparam int ADDR_MAX = (1 << ADDR_W) - 1;
  localparam int SEQ_MAX  = (1 << SEQ_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              scan_valid;
  logic [1:0]        lastEnd;
  logic              ram_ready;
  logic [DATA_W-1:0] ramData;
  logic [SEQ_W-1:0]  seqNum;
  logic              w_e_RAM;
  logic [ADDR_W-1:0] seqWire;
  logic              busy;
  logic              done;
  logic [SEQ_W:0]    count;
  logic              overflow;
  logic              code_err;

  always #5 clk = ~clk;

  taglist_gen_param #(
    .ADDR_W (ADDR_W),
    .SEQ_W  (SEQ_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_1KHz   (clk),
    .reset      (reset),
    .start      (start),
    .scan_valid (scan_valid),
    .lastEnd    (lastEnd),
    .ram_ready  (ram_ready),
    .ramData    (ramData),
    .seqNum     (seqNum),
    .w_e_RAM    (w_e_RAM),
    .seqWire    (seqWire),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .overflow   (overflow),
    .code_err   (code_err)
  );

  typedef struct {
    int seq;
    int first;
    int last;
    bit fin;
  } ent_t;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] codes[$];
  ent_t       exp_q[$];
  bit         ends_q[$];
  int         addrs_q[$];
  bit         exp_ovf;
  bit         exp_cerr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] pack(input ent_t e);
    logic [63:0] v;
    v = 64'(e.fin) + 64'(e.last) * 64'd2
      + 64'(e.first) * (64'd1 << (ADDR_W + 1))
      + 64'(e.seq)   * (64'd1 << (2 * ADDR_W + 1));
    return v[DATA_W-1:0];
  endfunction

  // Walk the code list as the ROM would be read, listing expected entries
  task automatic build_model();
    int   addr  = 0;
    int   first = 0;
    int   seq   = 0;
    ent_t e;
    exp_q.delete(); ends_q.delete(); addrs_q.delete();
    exp_ovf  = 1'b0;
    exp_cerr = 1'b0;
    foreach (codes[i]) begin
      addrs_q.push_back(addr);
      if (codes[i] == 2'b01) exp_cerr = 1'b1;
      if (codes[i][1]) begin
        e.seq = seq; e.first = first; e.last = addr; e.fin = (codes[i] == 2'b11);
        exp_q.push_back(e);
        ends_q.push_back(1'b1);
        if (e.fin) break;
        if (seq == SEQ_MAX) begin
          exp_ovf = 1'b1;
          break;
        end
        seq++;
        addr++;
        first = addr;
      end else if (addr == ADDR_MAX) begin
        exp_ovf = 1'b1;
        e.seq = seq; e.first = first; e.last = addr; e.fin = 1'b1;
        exp_q.push_back(e);
        ends_q.push_back(1'b1);
        break;
      end else begin
        ends_q.push_back(1'b0);
        addr++;
      end
    end
  endtask

  task automatic run_scan(input int stall_first, input bit rnd_rdy, input bit rnd_valid,
                          input bit rnd_start);
    int idx = 0;
    int ent = 0;
    int cyc = 0;
    int stall = stall_first;
    bit prev_end = 0, prev_cont = 0, prev_acc = 0, prev_fin = 0;
    build_model();
    @(negedge clk);
    start = 1'b1; scan_valid = 1'b0; ram_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {busy, done}, 2'b10);
    check("start_clear", {seqWire, seqNum, count, overflow, code_err, w_e_RAM}, 64'd0);
    while (cyc < 20000) begin
      cyc++;
      if (prev_end)  check("latency_we", w_e_RAM, 1'b1);
      if (prev_cont) check("cont_no_we", w_e_RAM, 1'b0);
      if (prev_acc)  check("resume_scan", {busy, w_e_RAM}, 2'b10);
      if (prev_fin)  check("final_done", done, 1'b1);
      prev_end = 0; prev_cont = 0; prev_acc = 0; prev_fin = 0;
      start = 1'b0;
      if (done) break;
      if (w_e_RAM) begin
        if (ent >= exp_q.size()) begin
          check("extra_write", w_e_RAM, 1'b0);
          break;
        end
        check("entry_data", ramData, pack(exp_q[ent]));
        check("entry_seq", seqNum, exp_q[ent].seq);
        check("count_hold", count, ent);
        if (stall > 0) begin
          ram_ready = 1'b0;
          stall--;
        end else begin
          ram_ready = rnd_rdy ? ($urandom % 3 != 0) : 1'b1;
        end
        scan_valid = $urandom % 2;
        lastEnd    = 2'($urandom);
        if (rnd_start) start = ($urandom % 5 == 0);
        @(posedge clk);
        if (ram_ready) begin
          ent++;
          if (ent == exp_q.size()) prev_fin = 1'b1;
          else                     prev_acc = 1'b1;
        end
      end else if (busy) begin
        if (idx >= ends_q.size()) begin
          check("extra_marker", busy, 1'b0);
          break;
        end
        check("scan_addr", seqWire, addrs_q[idx]);
        lastEnd    = codes[idx];
        scan_valid = rnd_valid ? ($urandom % 3 != 0) : 1'b1;
        ram_ready  = $urandom % 2;
        if (rnd_start) start = ($urandom % 5 == 0);
        @(posedge clk);
        if (scan_valid) begin
          prev_end  = ends_q[idx];
          prev_cont = !ends_q[idx];
          idx++;
        end
      end else begin
        check("unexpected_idle", busy, 1'b1);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; scan_valid = 1'b0;
    check("done", {done, busy, w_e_RAM}, 3'b100);
    check("count", count, exp_q.size());
    check("overflow", overflow, exp_ovf);
    check("code_err", code_err, exp_cerr);
    check("entries_written", ent, exp_q.size());
    repeat (2) @(negedge clk);
    check("done_hold", {ramData, seqNum}, {pack(exp_q[exp_q.size()-1]), SEQ_W'(exp_q[exp_q.size()-1].seq)});
    check("count_hold_done", count, exp_q.size());
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; scan_valid = 1'b0; lastEnd = 2'b00; ram_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {ramData, seqNum, w_e_RAM, seqWire, busy, done, count, overflow, code_err}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done}, 2'b00);

    // Three sequences, ready always high
    codes = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
    run_scan(0, 1'b0, 1'b0, 1'b0);

    // Same list, first write held off for three cycles
    run_scan(3, 1'b0, 1'b0, 1'b0);

    // Reserved code inside a sequence
    codes = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
    run_scan(0, 1'b0, 1'b0, 1'b0);

    // Address space exhausted with continuation codes
    codes.delete();
    for (int i = 0; i < ADDR_MAX + 1; i++) codes.push_back(2'b00);
    run_scan(0, 1'b0, 1'b0, 1'b0);

    // Sequence space exhausted: one write per marker
    codes.delete();
    for (int i = 0; i < SEQ_MAX + 4; i++) codes.push_back(2'b10);
    run_scan(0, 1'b0, 1'b0, 1'b0);

    // Random code lists with random valid, ready and stray start pulses
    for (int r = 0; r < 6; r++) begin
      codes.delete();
      for (int i = 0; i < 30; i++) begin
        int k;
        k = $urandom % 10;
        codes.push_back(k < 6 ? 2'b00 : (k == 6 ? 2'b01 : (k < 9 ? 2'b10 : 2'b11)));
      end
      codes.push_back(2'b11);
      run_scan($urandom % 3, 1'b1, 1'b1, 1'b1);
    end

    // Reset asserted while a write is pending
    @(negedge clk);
    start = 1'b1; ram_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; scan_valid = 1'b1; lastEnd = 2'b00;
    @(negedge clk);
    lastEnd = 2'b10;
    @(negedge clk);
    scan_valid = 1'b0;
    check("we_before_reset", w_e_RAM, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("reset_async_we", w_e_RAM, 1'b0);
    check("reset_async_all", {ramData, seqNum, seqWire, busy, done, count, overflow, code_err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    codes = '{2'b10, 2'b11};
    run_scan(0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
